// File: rtl/sw_xbar_alloc_if.sv
// rtl/sw_xbar_alloc_if.sv - request/grant/select bundle between the switch inputs and the crossbar allocator
interface sw_xbar_alloc_if;
    logic [3:0] req;
    logic [1:0] dst0;
    logic [1:0] dst1;
    logic [1:0] dst2;
    logic [1:0] dst3;
    logic [3:0] gnt;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic [1:0] sel3;
    logic [3:0] busy;
    logic [3:0] err;

    modport master (
        output req, dst0, dst1, dst2, dst3,
        input  gnt, sel0, sel1, sel2, sel3, busy, err
    );

    modport slave (
        input  req, dst0, dst1, dst2, dst3,
        output gnt, sel0, sel1, sel2, sel3, busy, err
    );
endinterface

// File: rtl/sw_xbar_alloc.sv
// rtl/sw_xbar_alloc.sv - 4x4 crossbar allocator: per-output round-robin with packet hold and watchdog
module sw_xbar_alloc #(
    parameter int TMO = 64
) (
    input logic           clk,
    input logic           rst,
    sw_xbar_alloc_if.slave bus
);
    localparam int             CW      = $clog2(TMO);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TMO - 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t        state_q [4];
    state_t        state_d [4];
    logic [1:0]    ptr_q   [4];
    logic [1:0]    ptr_d   [4];
    logic [1:0]    own_q   [4];
    logic [1:0]    own_d   [4];
    logic [CW-1:0] cnt_q   [4];
    logic [CW-1:0] cnt_d   [4];
    logic [3:0]    gnt_q, gnt_d;
    logic [3:0]    blk_q, blk_d;
    logic [3:0]    err_q, err_d;

    logic [1:0]    dst  [4];
    logic [3:0]    cand [4];

    assign dst[0] = bus.dst0;
    assign dst[1] = bus.dst1;
    assign dst[2] = bus.dst2;
    assign dst[3] = bus.dst3;

    // Granted inputs never compete, so an input's dst is ignored once it owns an output.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            cand[o] = '0;
            for (int i = 0; i < 4; i++) begin
                cand[o][i] = bus.req[i] && (dst[i] == 2'(o)) && !gnt_q[i] && !blk_q[i];
            end
        end
    end

    always_comb begin
        gnt_d = gnt_q;
        err_d = '0;
        blk_d = blk_q & bus.req;
        for (int o = 0; o < 4; o++) begin : g_out
            logic       found;
            logic [1:0] pick;
            logic [1:0] idx;
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            own_d[o]   = own_q[o];
            cnt_d[o]   = cnt_q[o];
            found      = 1'b0;
            pick       = 2'd0;
            idx        = 2'd0;
            case (state_q[o])
                S_IDLE: begin
                    for (int k = 0; k < 4; k++) begin
                        idx = ptr_q[o] + 2'(k);
                        if (!found && cand[o][idx]) begin
                            found = 1'b1;
                            pick  = idx;
                        end
                    end
                    if (found) begin
                        state_d[o]  = S_BUSY;
                        own_d[o]    = pick;
                        ptr_d[o]    = pick + 2'd1;
                        cnt_d[o]    = '0;
                        gnt_d[pick] = 1'b1;
                    end
                end
                default: begin
                    if (!bus.req[own_q[o]]) begin
                        state_d[o]        = S_IDLE;
                        gnt_d[own_q[o]]   = 1'b0;
                    end else if (cnt_q[o] == CNT_MAX) begin
                        // Stuck owner: force release and keep it out until it drops req.
                        state_d[o]        = S_IDLE;
                        gnt_d[own_q[o]]   = 1'b0;
                        blk_d[own_q[o]]   = 1'b1;
                        err_d[o]          = 1'b1;
                    end else begin
                        cnt_d[o] = cnt_q[o] + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            blk_q <= '0;
            err_q <= '0;
            for (int o = 0; o < 4; o++) begin
                state_q[o] <= S_IDLE;
                ptr_q[o]   <= '0;
                own_q[o]   <= '0;
                cnt_q[o]   <= '0;
            end
        end else begin
            gnt_q <= gnt_d;
            blk_q <= blk_d;
            err_q <= err_d;
            for (int o = 0; o < 4; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                own_q[o]   <= own_d[o];
                cnt_q[o]   <= cnt_d[o];
            end
        end
    end

    // The owner register doubles as the select, so sel holds its value after release.
    assign bus.sel0 = own_q[0];
    assign bus.sel1 = own_q[1];
    assign bus.sel2 = own_q[2];
    assign bus.sel3 = own_q[3];
    assign bus.gnt  = gnt_q;
    assign bus.err  = err_q;
    assign bus.busy = {state_q[3] == S_BUSY, state_q[2] == S_BUSY,
                       state_q[1] == S_BUSY, state_q[0] == S_BUSY};
endmodule
